fir_tdm: RTL and testbench
==========================

FIR_TDM -- requirements
Module: fir_tdm

Interface
REQ-001 Parameter DATA_W, default 16: sample and output width, signed two's complement.
REQ-002 Parameter COEF_W, default 16: coefficient width, signed two's complement.
REQ-003 Parameter N_TAPS, default 10: taps per channel, range 2..64.
REQ-004 Parameter N_CH, default 2: independent channels sharing one coefficient set, range 1..16.
REQ-005 Parameter COEF_FRAC, default 15: fractional bits of coefficients; output = round(sum >> COEF_FRAC).
REQ-006 clock  in  1  single clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 in_valid  in  1  input sample present.
REQ-009 in_ready  out  1  block can accept a sample this cycle.
REQ-010 in_ch  in  max(1,$clog2(N_CH))  channel of the input sample.
REQ-011 in_data  in  DATA_W  input sample x[n].
REQ-012 coef_we  in  1  coefficient write strobe.
REQ-013 coef_addr  in  $clog2(N_TAPS)  tap index k.
REQ-014 coef_data  in  COEF_W  coefficient value c[k].
REQ-015 out_valid  out  1  one-cycle result strobe; no backpressure.
REQ-016 out_ch  out  width of in_ch  channel of the result.
REQ-017 out_data  out  DATA_W  filter output y[n].
REQ-018 coef_err  out  1  one-cycle pulse on a rejected coefficient write.

Function
REQ-019 Each channel SHALL keep a private N_TAPS-deep history; output y[n] = sum over k=0..N_TAPS-1 of c[k]*x[n-k], x[n] newest.
REQ-020 A sample SHALL be accepted when in_valid && in_ready; it is written into its channel history before the MAC pass.
REQ-021 FSM states: IDLE (in_ready=1), MAC (N_TAPS cycles, one product per cycle via a single multiplier), OUT (one cycle, out_valid=1); IDLE->MAC on accept, MAC->OUT after tap N_TAPS-1, OUT->IDLE unconditionally.
REQ-022 Latency: accept at edge t gives out_valid at cycle t+N_TAPS+1; throughput one sample per N_TAPS+2 cycles.
REQ-023 in_ready SHALL be 0 in MAC and OUT; in_valid in those states is ignored and not consumed.
REQ-024 Accumulator width DATA_W+COEF_W+$clog2(N_TAPS), no intermediate overflow.
REQ-025 Rounding: add 2^(COEF_FRAC-1), arithmetic shift right by COEF_FRAC (round half up).
REQ-026 Saturation: rounded result clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-027 out_data and out_ch SHALL hold their last values outside OUT.
REQ-028 A sample with in_ch >= N_CH SHALL be accepted, discarded, leave all histories unchanged and produce no out_valid.
REQ-029 coef_we is honoured only in IDLE with coef_addr < N_TAPS; the write is visible to the next accepted sample.
REQ-030 coef_we in MAC/OUT, or with coef_addr >= N_TAPS, SHALL be dropped and pulse coef_err on the following cycle.
REQ-031 coef_we and an accepted sample in the same IDLE cycle: coefficient written first, the sample uses the new value.

Reset
REQ-032 While reset=0 at an edge: state=IDLE, all histories and coefficients =0, out_valid=0, out_data=0, out_ch=0, coef_err=0.
REQ-033 Reset mid-MAC or mid-OUT SHALL abort the pass with no out_valid; in_ready=1 on the first cycle after release.

Structure
REQ-034 Package fir_pkg SHALL hold the FSM state enum, default parameter constants and the accumulator-width function.
REQ-035 Sub-module fir_mac SHALL contain the multiplier, accumulator, rounding and saturation; fir_tdm holds the FSM, histories and coefficients.

Verification
REQ-036 Impulse: c = {0F85,079E,08D8,09C0,0A3C,0A3C,09C0,08D8,079E,0F85}, ch0 x=4000 then 0s -> y = 07C3, 03CF, 046C, ... (c[k]/2, round half up).
REQ-037 Saturation: all c=7FFF, 10 samples 7FFF -> last y=7FFF; 10 samples 8000 -> last y=8000.
REQ-038 Channel isolation: ch0 impulse 4000 interleaved with ch1 zeros -> ch1 outputs all 0000, ch0 matches REQ-036.
REQ-039 Handshake/latency: in_valid held high -> accepts spaced exactly N_TAPS+2 cycles, out_valid N_TAPS+1 cycles after each accept.
REQ-040 Coefficient error: coef_we during MAC, and coef_addr=10 in IDLE -> coef_err pulses, coefficients unchanged.
REQ-041 Reset in MAC cycle 3 -> no out_valid, histories 0, next impulse reproduces REQ-036.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } fir_state_e;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_COEF_W    = 16;
  localparam int DEF_N_TAPS    = 10;
  localparam int DEF_N_CH      = 2;
  localparam int DEF_COEF_FRAC = 15;

  // Wide enough that N_TAPS full-scale products never overflow.
  function automatic int acc_width(input int data_w, input int coef_w, input int n_taps);
    return data_w + coef_w + $clog2(n_taps);
  endfunction

  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/fir_tdm_if.sv
// Sample, coefficient and result signals of fir_tdm.
interface fir_tdm_if
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int N_TAPS = DEF_N_TAPS,
  parameter int N_CH   = DEF_N_CH
) ();
  localparam int CH_W   = ch_width(N_CH);
  localparam int ADDR_W = $clog2(N_TAPS);

  logic              in_valid;
  logic              in_ready;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_data;
  logic              coef_we;
  logic [ADDR_W-1:0] coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] out_data;
  logic              coef_err;

  modport master (
    output in_valid, in_ch, in_data, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out_ch, out_data, coef_err
  );

  modport slave (
    input  in_valid, in_ch, in_data, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out_ch, out_data, coef_err
  );
endinterface

// File: rtl/fir_mac.sv
// Single-multiplier accumulator with round-half-up and output saturation.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int N_TAPS    = DEF_N_TAPS,
  parameter int COEF_FRAC = DEF_COEF_FRAC
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] c,
  output logic        [DATA_W-1:0] y
);
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, N_TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (COEF_FRAC - 1);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q, acc_d, rnd, shf;

  assign prod  = x * c;
  assign acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign rnd   = acc_d + HALF;
  assign shf   = rnd >>> COEF_FRAC;

  always_ff @(posedge clock) begin
    if (!reset)   acc_q <= '0;
    else if (clr) acc_q <= '0;
    else if (en)  acc_q <= acc_d;
  end

  // Result fits when every bit above the output sign bit matches it.
  always_comb begin
    y = shf[DATA_W-1:0];
    if (shf[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){shf[ACC_W-1]}})
      y = shf[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end
endmodule

// File: rtl/fir_tdm.sv
// Multi-channel FIR: per-channel histories and a shared coefficient set,
// one tap per cycle through fir_mac.
module fir_tdm
  import fir_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int N_TAPS    = DEF_N_TAPS,
  parameter int N_CH      = DEF_N_CH,
  parameter int COEF_FRAC = DEF_COEF_FRAC
) (
  input  logic      clock,
  input  logic      reset,
  fir_tdm_if.slave  bus
);
  localparam int CH_W   = ch_width(N_CH);
  localparam int ADDR_W = $clog2(N_TAPS);
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(N_TAPS - 1);

  fir_state_e        state_q, state_d;
  logic [ADDR_W-1:0] tap_q;
  logic [CH_W-1:0]   ch_q, out_ch_q;
  logic [DATA_W-1:0] out_data_q, mac_y;
  logic              coef_err_q;
  logic [DATA_W-1:0] hist [N_CH][N_TAPS];
  logic [COEF_W-1:0] coef [N_TAPS];

  logic accept, ch_ok, coef_ok, last_tap;

  assign accept   = (state_q == S_IDLE) && bus.in_valid;
  assign ch_ok    = int'(bus.in_ch) < N_CH;
  assign coef_ok  = (state_q == S_IDLE) && (int'(bus.coef_addr) < N_TAPS);
  assign last_tap = (state_q == S_MAC) && (tap_q == LAST_TAP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && ch_ok) state_d = S_MAC;
      S_MAC:   if (tap_q == LAST_TAP) state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A sample on an out-of-range channel is consumed but never enters a history.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tap_q      <= '0;
      ch_q       <= '0;
      out_ch_q   <= '0;
      out_data_q <= '0;
      coef_err_q <= 1'b0;
      for (int k = 0; k < N_TAPS; k++) coef[k] <= '0;
      for (int h = 0; h < N_CH; h++)
        for (int k = 0; k < N_TAPS; k++) hist[h][k] <= '0;
    end else begin
      state_q    <= state_d;
      coef_err_q <= bus.coef_we && !coef_ok;
      if (bus.coef_we && coef_ok) coef[bus.coef_addr] <= bus.coef_data;
      if (accept && ch_ok) begin
        ch_q  <= bus.in_ch;
        tap_q <= '0;
        for (int k = N_TAPS - 1; k > 0; k--) hist[bus.in_ch][k] <= hist[bus.in_ch][k-1];
        hist[bus.in_ch][0] <= bus.in_data;
      end else if (state_q == S_MAC) begin
        tap_q <= tap_q + 1'b1;
      end
      if (last_tap) begin
        out_data_q <= mac_y;
        out_ch_q   <= ch_q;
      end
    end
  end

  fir_mac #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .N_TAPS    (N_TAPS),
    .COEF_FRAC (COEF_FRAC)
  ) u_mac (
    .clock (clock),
    .reset (reset),
    .clr   (accept && ch_ok),
    .en    (state_q == S_MAC),
    .x     (hist[ch_q][tap_q]),
    .c     (coef[tap_q]),
    .y     (mac_y)
  );

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign bus.coef_err  = coef_err_q;
endmodule

// File: tb/tb_fir_tdm.sv
// Directed bench for fir_tdm: vector table plus handshake, saturation,
// coefficient-error and reset-abort sequences.
module tb_fir_tdm;
  import fir_pkg::*;

  localparam int N_TAPS = 10;
  localparam int N_CH   = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fir_tdm_if #(.DATA_W(16), .COEF_W(16), .N_TAPS(N_TAPS), .N_CH(N_CH)) bus ();

  fir_tdm #(
    .DATA_W(16), .COEF_W(16), .N_TAPS(N_TAPS), .N_CH(N_CH), .COEF_FRAC(15)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] x;
    bit          exp_v;
    logic [15:0] exp_y;
  } vec_t;

  vec_t        vecs [17];
  logic [15:0] cimp [10];
  int          n_tests = 0;
  int          n_fail  = 0;

  bit          got;
  logic [15:0] y;
  logic [1:0]  och;
  int          lat;
  int          acc_c [3];
  int          out_c [2];
  int          na, no;
  bit          seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check("idle_timeout", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic write_coef(input logic [3:0] addr, input logic [15:0] data, input bit exp_err);
    wait_idle();
    bus.coef_we   = 1'b1;
    bus.coef_addr = addr;
    bus.coef_data = data;
    @(negedge clock);
    bus.coef_we = 1'b0;
    check("coef_err_after_write", {31'd0, bus.coef_err}, {31'd0, exp_err});
  endtask

  task automatic load_impulse_coefs();
    for (int k = 0; k < N_TAPS; k++) write_coef(4'(k), cimp[k], 1'b0);
  endtask

  task automatic run_sample(input logic [1:0] ch, input logic [15:0] x,
                            output bit g, output logic [15:0] yo,
                            output logic [1:0] cho, output int lt);
    wait_idle();
    bus.in_valid = 1'b1;
    bus.in_ch    = ch;
    bus.in_data  = x;
    @(negedge clock);
    bus.in_valid = 1'b0;
    g   = 1'b0;
    yo  = '0;
    cho = '0;
    lt  = 1;
    while (!g && lt <= 20) begin
      if (bus.out_valid) begin
        g   = 1'b1;
        yo  = bus.out_data;
        cho = bus.out_ch;
      end else begin
        @(negedge clock);
        lt++;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cimp[0] = 16'h0F85; cimp[1] = 16'h079E; cimp[2] = 16'h08D8; cimp[3] = 16'h09C0;
    cimp[4] = 16'h0A3C; cimp[5] = 16'h0A3C; cimp[6] = 16'h09C0; cimp[7] = 16'h08D8;
    cimp[8] = 16'h079E; cimp[9] = 16'h0F85;

    vecs[0]  = '{2'd0, 16'h4000, 1'b1, 16'h07C3};
    vecs[1]  = '{2'd1, 16'h0000, 1'b1, 16'h0000};
    vecs[2]  = '{2'd0, 16'h0000, 1'b1, 16'h03CF};
    vecs[3]  = '{2'd3, 16'h7FFF, 1'b0, 16'h0000};
    vecs[4]  = '{2'd1, 16'h0000, 1'b1, 16'h0000};
    vecs[5]  = '{2'd0, 16'h0000, 1'b1, 16'h046C};
    vecs[6]  = '{2'd2, 16'h4000, 1'b1, 16'h07C3};
    vecs[7]  = '{2'd0, 16'h0000, 1'b1, 16'h04E0};
    vecs[8]  = '{2'd2, 16'h0000, 1'b1, 16'h03CF};
    vecs[9]  = '{2'd0, 16'h0000, 1'b1, 16'h051E};
    vecs[10] = '{2'd0, 16'h0000, 1'b1, 16'h051E};
    vecs[11] = '{2'd0, 16'h0000, 1'b1, 16'h04E0};
    vecs[12] = '{2'd0, 16'h0000, 1'b1, 16'h046C};
    vecs[13] = '{2'd0, 16'h0000, 1'b1, 16'h03CF};
    vecs[14] = '{2'd1, 16'h0000, 1'b1, 16'h0000};
    vecs[15] = '{2'd0, 16'h0000, 1'b1, 16'h07C3};
    vecs[16] = '{2'd0, 16'h0000, 1'b1, 16'h0000};

    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.in_data   = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;

    // Reset state
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data",  {16'd0, bus.out_data},  32'd0);
    check("rst_coef_err",  {31'd0, bus.coef_err},  32'd0);

    // Impulse response, channel isolation and discarded channel
    load_impulse_coefs();
    for (int i = 0; i < 17; i++) begin
      run_sample(vecs[i].ch, vecs[i].x, got, y, och, lat);
      check($sformatf("vec%0d_valid", i), {31'd0, got}, {31'd0, vecs[i].exp_v});
      if (vecs[i].exp_v) begin
        check($sformatf("vec%0d_y", i),   {16'd0, y},  {16'd0, vecs[i].exp_y});
        check($sformatf("vec%0d_ch", i),  {30'd0, och}, {30'd0, vecs[i].ch});
        check($sformatf("vec%0d_lat", i), lat, N_TAPS + 1);
      end
    end
    run_sample(2'd1, 16'h0000, got, y, och, lat);
    @(negedge clock);
    check("hold_out_ch", {30'd0, bus.out_ch}, 32'd1);

    // Handshake: in_valid held high
    wait_idle();
    na = 0; no = 0;
    acc_c = '{0, 0, 0};
    out_c = '{0, 0};
    bus.in_ch = 2'd0; bus.in_data = 16'h0000; bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      if (bus.in_ready && na < 3) begin acc_c[na] = cyc; na++; end
      if (bus.out_valid && no < 2) begin out_c[no] = cyc; no++; end
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    check("hs_accepts",  na, 3);
    check("hs_outs",     no, 2);
    check("hs_space01",  acc_c[1] - acc_c[0], N_TAPS + 2);
    check("hs_space12",  acc_c[2] - acc_c[1], N_TAPS + 2);
    check("hs_lat0",     out_c[0] - acc_c[0], N_TAPS + 1);
    check("hs_lat1",     out_c[1] - acc_c[1], N_TAPS + 1);

    // Saturation
    for (int k = 0; k < N_TAPS; k++) write_coef(4'(k), 16'h7FFF, 1'b0);
    for (int i = 0; i < N_TAPS; i++) run_sample(2'd0, 16'h7FFF, got, y, och, lat);
    check("sat_pos", {16'd0, y}, 32'h7FFF);
    for (int i = 0; i < N_TAPS; i++) run_sample(2'd0, 16'h8000, got, y, och, lat);
    check("sat_neg", {16'd0, y}, 32'h8000);

    // Coefficient write rejected during MAC and for an out-of-range address
    load_impulse_coefs();
    wait_idle();
    bus.in_valid = 1'b1; bus.in_ch = 2'd1; bus.in_data = 16'h0000;
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.coef_we = 1'b1; bus.coef_addr = 4'd0; bus.coef_data = 16'h7FFF;
    @(negedge clock);
    bus.coef_we = 1'b0;
    check("err_mac_pulse", {31'd0, bus.coef_err}, 32'd1);
    @(negedge clock);
    check("err_mac_single", {31'd0, bus.coef_err}, 32'd0);
    write_coef(4'd10, 16'h7FFF, 1'b1);
    run_sample(2'd1, 16'h4000, got, y, och, lat);
    check("err_c0_kept", {16'd0, y}, 32'h07C3);
    run_sample(2'd1, 16'h0000, got, y, och, lat);
    check("err_c1_kept", {16'd0, y}, 32'h03CF);

    // Coefficient write and accept in the same cycle
    wait_idle();
    bus.coef_we = 1'b1; bus.coef_addr = 4'd0; bus.coef_data = 16'h2000;
    bus.in_valid = 1'b1; bus.in_ch = 2'd1; bus.in_data = 16'h4000;
    @(negedge clock);
    bus.coef_we = 1'b0; bus.in_valid = 1'b0;
    lat = 1; got = 1'b0;
    while (!got && lat <= 20) begin
      if (bus.out_valid) begin got = 1'b1; y = bus.out_data; end
      else begin @(negedge clock); lat++; end
    end
    check("same_cycle_coef", {16'd0, y}, 32'h146C);

    // Reset during MAC cycle 3
    wait_idle();
    bus.in_valid = 1'b1; bus.in_ch = 2'd0; bus.in_data = 16'h4000;
    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort_out_data", {16'd0, bus.out_data}, 32'd0);
    check("abort_out_ch",   {30'd0, bus.out_ch},   32'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid) seen = 1'b1;
      @(negedge clock);
    end
    check("abort_no_out", {31'd0, seen}, 32'd0);
    run_sample(2'd0, 16'h4000, got, y, och, lat);
    check("abort_coef_zero", {16'd0, y}, 32'h0000);
    load_impulse_coefs();
    run_sample(2'd0, 16'h0000, got, y, och, lat);
    check("abort_hist_tap1", {16'd0, y}, 32'h03CF);
    run_sample(2'd1, 16'h4000, got, y, och, lat);
    check("abort_impulse0", {16'd0, y}, 32'h07C3);
    run_sample(2'd1, 16'h0000, got, y, och, lat);
    check("abort_impulse1", {16'd0, y}, 32'h03CF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
